// File: rtl/control_host_link_if.sv
// control_host_link_if: groups the host pipe endpoints and the memory_control
// command/result stream into one bundle. The master side is the environment
// (host glue plus memory_control); the slave side is control_host_link.
interface control_host_link_if #(
   parameter int DEPTH_LOG2 = 4
);
   // host pipe-in (commands toward memory_control)
   logic                  pipe_in_write;
   logic [31:0]           pipe_in_data;
   // command stream toward memory_control (first-word-fall-through)
   logic                  cmd_empty;
   logic                  cmd_read;
   logic [31:0]           cmd_data;
   // result stream from memory_control
   logic                  res_valid;
   logic [31:0]           res_data;
   logic                  res_read;
   // host pipe-out (results toward host)
   logic                  pipe_out_read;
   logic [31:0]           pipe_out_data;
   // status
   logic [DEPTH_LOG2:0]   cmd_count;
   logic [DEPTH_LOG2:0]   res_count;
   logic                  cmd_full;
   logic                  res_empty;
   logic                  overflow;
   logic                  underflow;

   modport master (
      output pipe_in_write, pipe_in_data, cmd_read, res_valid, res_data, pipe_out_read,
      input  cmd_empty, cmd_data, res_read, pipe_out_data,
             cmd_count, res_count, cmd_full, res_empty, overflow, underflow
   );

   modport slave (
      input  pipe_in_write, pipe_in_data, cmd_read, res_valid, res_data, pipe_out_read,
      output cmd_empty, cmd_data, res_read, pipe_out_data,
             cmd_count, res_count, cmd_full, res_empty, overflow, underflow
   );
endinterface

// File: rtl/control_host_link.sv
// control_host_link: two independent circular FIFOs between the host pipe
// endpoints and memory_control. The command FIFO turns host pipe-in words into
// a first-word-fall-through stream; the result FIFO drains memory_control
// results for the host pipe-out. Optional macro HOST_LINK_FLUSH_EN adds a
// synchronous flush port that empties both FIFOs without touching the sticky
// error flags.
module control_host_link #(
   parameter int DEPTH_LOG2 = 4
) (
   input  logic clk,
   input  logic rst,
`ifdef HOST_LINK_FLUSH_EN
   input  logic flush,
`endif
   control_host_link_if.slave bus
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
   localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
   localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = (DEPTH_LOG2)'(1);

   // storage and pointers
   logic [31:0]           cmd_mem [DEPTH];
   logic [31:0]           res_mem [DEPTH];
   logic [DEPTH_LOG2-1:0] cmd_wr_ptr, cmd_rd_ptr;
   logic [DEPTH_LOG2-1:0] res_wr_ptr, res_rd_ptr;
   logic [DEPTH_LOG2:0]   cmd_cnt, res_cnt;
   logic                  overflow_q, underflow_q;

   // status decoded from the registered counts
   logic cmd_empty_w, cmd_full_w, res_empty_w, res_full_w;
   logic cmd_push, cmd_pop, res_push, res_pop, res_read_w;

   assign cmd_empty_w = (cmd_cnt == '0);
   assign cmd_full_w  = (cmd_cnt == CNT_FULL);
   assign res_empty_w = (res_cnt == '0);
   assign res_full_w  = (res_cnt == CNT_FULL);

   // Push/pop qualification and result back-pressure.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned and infers a latch.
      cmd_pop    = 1'b0;
      cmd_push   = 1'b0;
      res_read_w = 1'b0;
      res_pop    = 1'b0;
      cmd_pop    = bus.cmd_read & ~cmd_empty_w;
      // a pop in the same cycle frees the slot a write into a full FIFO needs
      cmd_push   = bus.pipe_in_write & (~cmd_full_w | cmd_pop);
`ifdef HOST_LINK_FLUSH_EN
      res_read_w = bus.res_valid & ~res_full_w & ~flush;
`else
      res_read_w = bus.res_valid & ~res_full_w;
`endif
      res_pop    = bus.pipe_out_read & ~res_empty_w;
   end

   assign res_push = res_read_w;

   // Command FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_cnt    <= '0;
      end
`ifdef HOST_LINK_FLUSH_EN
      else if (flush) begin
         cmd_wr_ptr <= '0;
         cmd_rd_ptr <= '0;
         cmd_cnt    <= '0;
      end
`endif
      else begin
         if (cmd_push) cmd_wr_ptr <= cmd_wr_ptr + PTR_ONE;
         if (cmd_pop)  cmd_rd_ptr <= cmd_rd_ptr + PTR_ONE;
         unique case ({cmd_push, cmd_pop})
            2'b10:   cmd_cnt <= cmd_cnt + CNT_ONE;
            2'b01:   cmd_cnt <= cmd_cnt - CNT_ONE;
            default: cmd_cnt <= cmd_cnt;
         endcase
      end
   end

   // Result FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
         res_cnt    <= '0;
      end
`ifdef HOST_LINK_FLUSH_EN
      else if (flush) begin
         res_wr_ptr <= '0;
         res_rd_ptr <= '0;
         res_cnt    <= '0;
      end
`endif
      else begin
         if (res_push) res_wr_ptr <= res_wr_ptr + PTR_ONE;
         if (res_pop)  res_rd_ptr <= res_rd_ptr + PTR_ONE;
         unique case ({res_push, res_pop})
            2'b10:   res_cnt <= res_cnt + CNT_ONE;
            2'b01:   res_cnt <= res_cnt - CNT_ONE;
            default: res_cnt <= res_cnt;
         endcase
      end
   end

   // FIFO storage writes.
   always_ff @(posedge clk) begin
      // NOTE: the RAMs are deliberately not reset; the reset pointers/counts make stale words unreachable.
      if (cmd_push) cmd_mem[cmd_wr_ptr] <= bus.pipe_in_data;
      if (res_push) res_mem[res_wr_ptr] <= bus.res_data;
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (bus.pipe_in_write & ~cmd_push)    overflow_q  <= 1'b1;
         if (bus.pipe_out_read & res_empty_w)  underflow_q <= 1'b1;
      end
   end

   // outputs
   assign bus.cmd_empty     = cmd_empty_w;
   assign bus.cmd_full      = cmd_full_w;
   assign bus.cmd_data      = cmd_empty_w ? 32'h0 : cmd_mem[cmd_rd_ptr];
   assign bus.cmd_count     = cmd_cnt;
   assign bus.res_read      = res_read_w;
   assign bus.res_empty     = res_empty_w;
   assign bus.pipe_out_data = res_empty_w ? 32'h0 : res_mem[res_rd_ptr];
   assign bus.res_count     = res_cnt;
   assign bus.overflow      = overflow_q;
   assign bus.underflow     = underflow_q;

endmodule

// File: tb/tb_control_host_link.sv
// tb_control_host_link: directed plus randomized stimulus against a queue-based
// reference model. The model process predicts FIFO contents and flags at each
// rising edge; the monitor compares the DUT against it at each falling edge.
`timescale 1ns/1ps
module tb_control_host_link;
   localparam int DEPTH_LOG2 = 4;
   localparam int DEPTH      = 2 ** DEPTH_LOG2;

   logic clk = 1'b0;
   logic rst;
`ifdef HOST_LINK_FLUSH_EN
   logic flush;
`endif

   control_host_link_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus ();

   control_host_link #(.DEPTH_LOG2(DEPTH_LOG2)) dut (
      .clk   (clk),
      .rst   (rst),
`ifdef HOST_LINK_FLUSH_EN
      .flush (flush),
`endif
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model state: FIFO contents as plain queues plus sticky flags
   logic [31:0] cmd_q [$];
   logic [31:0] res_q [$];
   bit          m_overflow  = 1'b0;
   bit          m_underflow = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit flush_now();
`ifdef HOST_LINK_FLUSH_EN
      return flush;
`else
      return 1'b0;
`endif
   endfunction

   // Model: apply this cycle's inputs at the edge.
   always @(posedge clk) begin
      bit c_pop, c_push, r_push, r_pop, fl;
      fl     = flush_now();
      c_pop  = bus.cmd_read && (cmd_q.size() > 0);
      c_push = bus.pipe_in_write && ((cmd_q.size() < DEPTH) || c_pop);
      r_push = bus.res_valid && (res_q.size() < DEPTH) && !fl;
      r_pop  = bus.pipe_out_read && (res_q.size() > 0);
      if (rst) begin
         cmd_q.delete();
         res_q.delete();
         m_overflow  = 1'b0;
         m_underflow = 1'b0;
      end else begin
         if (bus.pipe_in_write && !c_push)             m_overflow  = 1'b1;
         if (bus.pipe_out_read && (res_q.size() == 0)) m_underflow = 1'b1;
         if (fl) begin
            cmd_q.delete();
            res_q.delete();
         end else begin
            if (c_pop)  void'(cmd_q.pop_front());
            if (c_push) cmd_q.push_back(bus.pipe_in_data);
            if (r_pop)  void'(res_q.pop_front());
            if (r_push) res_q.push_back(bus.res_data);
         end
      end
   end

   // Monitor: compare DUT outputs with the model mid-cycle.
   always @(negedge clk) begin
      logic [31:0] exp_cmd_head, exp_res_head;
      bit          exp_rr;
      exp_cmd_head = (cmd_q.size() > 0) ? cmd_q[0] : 32'h0;
      exp_res_head = (res_q.size() > 0) ? res_q[0] : 32'h0;
      exp_rr       = bus.res_valid && (res_q.size() < DEPTH) && !flush_now();
      check("cmd_count",     32'(bus.cmd_count),     32'(cmd_q.size()));
      check("res_count",     32'(bus.res_count),     32'(res_q.size()));
      check("cmd_empty",     32'(bus.cmd_empty),     32'(cmd_q.size() == 0));
      check("cmd_full",      32'(bus.cmd_full),      32'(cmd_q.size() == DEPTH));
      check("res_empty",     32'(bus.res_empty),     32'(res_q.size() == 0));
      check("cmd_data",      bus.cmd_data,           exp_cmd_head);
      check("pipe_out_data", bus.pipe_out_data,      exp_res_head);
      check("res_read",      32'(bus.res_read),      32'(exp_rr));
      check("overflow",      32'(bus.overflow),      32'(m_overflow));
      check("underflow",     32'(bus.underflow),     32'(m_underflow));
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.pipe_in_write = 1'b0;
      bus.pipe_in_data  = 32'h0;
      bus.cmd_read      = 1'b0;
      bus.res_valid     = 1'b0;
      bus.res_data      = 32'h0;
      bus.pipe_out_read = 1'b0;
`ifdef HOST_LINK_FLUSH_EN
      flush = 1'b0;
`endif
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      repeat (2) step();
      rst = 1'b0;

      // reset values against spec constants
      @(negedge clk);
      check("rst_cmd_empty", 32'(bus.cmd_empty), 32'd1);
      check("rst_res_empty", 32'(bus.res_empty), 32'd1);
      check("rst_cmd_data",  bus.cmd_data,       32'd0);
      check("rst_res_read",  32'(bus.res_read),  32'd0);

      // three writes, then three pops
      for (int v = 1; v <= 3; v++) begin
         step();
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(v);
      end
      step();
      idle();
      @(negedge clk);
      check("t1_count3", 32'(bus.cmd_count), 32'd3);
      check("t1_head",   bus.cmd_data,       32'd1);
      step();
      bus.cmd_read = 1'b1;
      repeat (3) step();
      idle();
      @(negedge clk);
      check("t1_empty_again", 32'(bus.cmd_empty), 32'd1);

      // 17 writes into a 16-deep FIFO
      for (int i = 1; i <= DEPTH + 1; i++) begin
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(100 + i);
         step();
      end
      idle();
      @(negedge clk);
      check("t2_full",     32'(bus.cmd_full),  32'd1);
      check("t2_overflow", 32'(bus.overflow),  32'd1);
      check("t2_head",     bus.cmd_data,       32'd101);
      step();
      bus.cmd_read = 1'b1;
      repeat (DEPTH) step();
      idle();

      // full FIFO with simultaneous pop and write: write accepted
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(200 + i);
         step();
      end
      bus.pipe_in_data = 32'(200 + DEPTH);
      bus.cmd_read     = 1'b1;
      step();
      idle();
      @(negedge clk);
      check("t2_simul_count",    32'(bus.cmd_count), 32'd16);
      check("t2_simul_overflow", 32'(bus.overflow),  32'd0);
      check("t2_simul_head",     bus.cmd_data,       32'd201);
      step();
      bus.cmd_read = 1'b1;
      repeat (DEPTH) step();
      idle();

      // result back-pressure: 0xA0..0xAF then 0xB0 held
      for (int i = 0; i <= DEPTH; i++) begin
         bus.res_valid = 1'b1;
         bus.res_data  = (i < DEPTH) ? 32'(32'hA0 + i) : 32'hB0;
         step();
      end
      step();
      @(negedge clk);
      check("t3_res_read_full", 32'(bus.res_read),  32'd0);
      check("t3_res_count",     32'(bus.res_count), 32'd16);
      step();
      bus.pipe_out_read = 1'b1;
      step();
      bus.pipe_out_read = 1'b0;
      repeat (2) step();
      bus.res_valid = 1'b0;
      @(negedge clk);
      check("t3_res_count_after", 32'(bus.res_count),    32'd16);
      check("t3_res_head",        bus.pipe_out_data,     32'hA1);
      step();
      bus.pipe_out_read = 1'b1;
      repeat (DEPTH) step();
      idle();

      // underflow on empty result FIFO
      bus.pipe_out_read = 1'b1;
      step();
      idle();
      @(negedge clk);
      check("t4_underflow", 32'(bus.underflow),     32'd1);
      check("t4_res_count", 32'(bus.res_count),     32'd0);
      check("t4_data",      bus.pipe_out_data,      32'd0);
      repeat (3) step();
      @(negedge clk);
      check("t4_underflow_sticky", 32'(bus.underflow), 32'd1);

      // wrap-around: 40 interleaved push/pop pairs on both FIFOs
      step();
      for (int i = 0; i < 40; i++) begin
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(1000 + i);
         bus.res_valid     = 1'b1;
         bus.res_data      = 32'(2000 + i);
         step();
         idle();
         bus.cmd_read      = 1'b1;
         bus.pipe_out_read = 1'b1;
         step();
         idle();
         @(negedge clk);
         check("t5_cmd_le1", 32'(bus.cmd_count <= 1), 32'd1);
         check("t5_res_le1", 32'(bus.res_count <= 1), 32'd1);
         step();
      end

      // randomized traffic
      for (int i = 0; i < 500; i++) begin
         bus.pipe_in_write = ($urandom_range(99) < 60);
         bus.pipe_in_data  = $urandom;
         bus.cmd_read      = ($urandom_range(99) < 45);
         bus.res_valid     = ($urandom_range(99) < 60);
         bus.res_data      = $urandom;
         bus.pipe_out_read = ($urandom_range(99) < 45);
`ifdef HOST_LINK_FLUSH_EN
         flush = ($urandom_range(99) < 3);
`endif
         step();
      end
      idle();

      // reset with 5 words buffered in each FIFO
      for (int i = 0; i < 5; i++) begin
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(3000 + i);
         bus.res_valid     = 1'b1;
         bus.res_data      = 32'(4000 + i);
         step();
      end
      idle();
      do_reset();
      @(negedge clk);
      check("t6_cmd_count", 32'(bus.cmd_count), 32'd0);
      check("t6_res_count", 32'(bus.res_count), 32'd0);
      check("t6_cmd_empty", 32'(bus.cmd_empty), 32'd1);
      check("t6_overflow",  32'(bus.overflow),  32'd0);
      check("t6_underflow", 32'(bus.underflow), 32'd0);

`ifdef HOST_LINK_FLUSH_EN
      // flush with buffered words and overflow set
      step();
      for (int i = 0; i <= DEPTH; i++) begin
         bus.pipe_in_write = 1'b1;
         bus.pipe_in_data  = 32'(5000 + i);
         bus.res_valid     = (i < 5);
         bus.res_data      = 32'(6000 + i);
         step();
      end
      idle();
      flush = 1'b1;
      bus.res_valid = 1'b1;
      step();
      idle();
      @(negedge clk);
      check("t7_cmd_count", 32'(bus.cmd_count), 32'd0);
      check("t7_res_count", 32'(bus.res_count), 32'd0);
      check("t7_overflow",  32'(bus.overflow),  32'd1);
`endif

      step();
      step();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
